// File: rtl/sub32_serial_pkg.sv
// Shared types and sizing helpers for the sliced serial subtractor.
package sub32_pkg;

  localparam int unsigned WIDTH_D = 32;
  localparam int unsigned SLICE_D = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int unsigned nslice(input int unsigned w, input int unsigned s);
    return w / s;
  endfunction

  // Index register needs at least one bit even for a single-slice build.
  function automatic int unsigned idx_w(input int unsigned w, input int unsigned s);
    return (nslice(w, s) > 1) ? $clog2(nslice(w, s)) : 1;
  endfunction

endpackage

// File: rtl/sub32_serial_if.sv
// Operand/result valid-ready bundle for sub32_serial.
interface sub32_serial_if
  import sub32_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_D
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, bout, ovf
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, bout, ovf
  );
endinterface

// File: rtl/sub32_serial_slice.sv
// Combinational SLICE-bit subtract with borrow-in/borrow-out.
module sub_slice #(
  parameter int unsigned SLICE = 8
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  input  logic             bin_i,
  output logic [SLICE-1:0] d_c,
  output logic             bout_c
);
  logic [SLICE:0] res;

  // Zero-extended difference; the top bit becomes the borrow.
  always_comb begin
    res = {1'b0, a_i} - {1'b0, b_i} - (SLICE+1)'(bin_i);
  end

  assign d_c    = res[SLICE-1:0];
  assign bout_c = res[SLICE];
endmodule

// File: rtl/sub32_serial.sv
// Multi-cycle subtractor, one slice per clock from the LSB, behind valid/ready.
// Define SUB32_SERIAL_SAT_EN to clamp diff to 0 when the final borrow is set.
module sub32_serial
  import sub32_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_D,
  parameter int unsigned SLICE = SLICE_D
) (
  input logic           clk,
  input logic           rst_n,
  sub32_serial_if.slave bus
);
  localparam int unsigned NSLICE = nslice(WIDTH, SLICE);
  localparam int unsigned IDX_W  = idx_w(WIDTH, SLICE);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               borrow_q, borrow_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bout_q, bout_d;
  logic               ovf_q, ovf_d;

  logic [SLICE-1:0]   sa, sb, sd;
  logic               sbo;
  logic [WIDTH-1:0]   work_nxt;

  sub_slice #(.SLICE(SLICE)) u_slice (
    .a_i    (sa),
    .b_i    (sb),
    .bin_i  (borrow_q),
    .d_c    (sd),
    .bout_c (sbo)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      work_q   <= work_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    work_d   = work_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    sa       = '0;
    sb       = '0;
    work_nxt = work_q;

    // Select the active slice and splice its result into the working value.
    for (int unsigned i = 0; i < NSLICE; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sa = a_q[i*SLICE +: SLICE];
        sb = b_q[i*SLICE +: SLICE];
        work_nxt[i*SLICE +: SLICE] = sd;
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d      = bus.a;
          b_d      = bus.b;
          borrow_d = 1'b0;
          idx_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        work_d   = work_nxt;
        borrow_d = sbo;
        idx_d    = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NSLICE-1)) begin
`ifdef SUB32_SERIAL_SAT_EN
          diff_d = sbo ? '0 : work_nxt;
`else
          diff_d = work_nxt;
`endif
          bout_d  = sbo;
          ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (work_nxt[WIDTH-1] != a_q[WIDTH-1]);
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_sub32_serial.sv
// Self-checking bench for sub32_serial: vector table, scoreboard queue, corner sequences.
module tb_sub32_serial;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sub32_serial_if #(.WIDTH(W)) bus ();

  sub32_serial #(.WIDTH(W), .SLICE(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] diff;
    logic        bout;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [31:0] diff;
    logic        bout;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sat(input logic [31:0] d, input logic bo);
`ifdef SUB32_SERIAL_SAT_EN
    return bo ? 32'h0 : d;
`else
    return d;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ed, input logic eb, input logic eo);
    exp_t e;
    int   cnt;
    cnt = 0;
    while (!bus.in_ready && cnt < 20) begin
      tick();
      cnt++;
    end
    chk("in_ready_wait", 32'(bus.in_ready), 32'(1));
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    e.diff = sat(ed, eb);
    e.bout = eb;
    e.ovf  = eo;
    exp_q.push_back(e);
    tick();
    bus.in_valid = 1'b0;
    chk("in_ready_after_accept", 32'(bus.in_ready), 32'(0));
  endtask

  task automatic collect(input string name);
    exp_t e;
    int   cnt;
    cnt = 0;
    while (!bus.out_valid && cnt < 20) begin
      if (bus.in_ready) begin
        n_err++;
        $display("FAIL %s in_ready_busy: got 1 expected 0 at cycle %0d", name, cnt);
      end
      tick();
      cnt++;
    end
    chk({name, "_latency"}, 32'(cnt), 32'(4));
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s scoreboard: got result expected none", name);
    end else begin
      e = exp_q.pop_front();
      chk({name, "_diff"}, bus.diff, e.diff);
      chk({name, "_bout"}, 32'(bus.bout), 32'(e.bout));
      chk({name, "_ovf"},  32'(bus.ovf),  32'(e.ovf));
    end
    if (bus.out_ready) begin
      tick();
      chk({name, "_out_valid_drop"}, 32'(bus.out_valid), 32'(0));
      chk({name, "_in_ready_back"},  32'(bus.in_ready),  32'(1));
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ed, input logic eb, input logic eo,
                        input string name);
    issue(a, b, ed, eb, eo);
    collect(name);
  endtask

  vec_t vecs[10];

  initial begin
    logic [31:0] ra, rb, rd;
    logic        rbo, rov;

    vecs[0] = '{32'h0000_0008, 32'h0000_0009, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[1] = '{32'h0000_000B, 32'h0000_0001, 32'h0000_000A, 1'b0, 1'b0};
    vecs[2] = '{32'h0000_000B, 32'h0000_000F, 32'hFFFF_FFFC, 1'b1, 1'b0};
    vecs[3] = '{32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1};
    vecs[4] = '{32'h0000_00FF, 32'h0000_0100, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[5] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0};
    vecs[6] = '{32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0};
    vecs[7] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1};
    vecs[8] = '{32'h0100_0000, 32'h0000_0001, 32'h00FF_FFFF, 1'b0, 1'b0};
    vecs[9] = '{32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b0};

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_in_ready",  32'(bus.in_ready),  32'(1));
    chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("rst_diff",      bus.diff,           32'h0);
    chk("rst_bout",      32'(bus.bout),      32'(0));
    chk("rst_ovf",       32'(bus.ovf),       32'(0));

    // Table vectors back-to-back with out_ready held high.
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].bout, vecs[i].ovf,
             $sformatf("vec%0d", i));
    end

    // Downstream stall in DONE while upstream keeps offering new operands.
    bus.out_ready = 1'b0;
    issue(32'h8, 32'h9, 32'hFFFF_FFFF, 1'b1, 1'b0);
    collect("stall");
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = 32'h0000_1111;
      bus.b        = 32'h0000_0001;
      tick();
      chk("stall_out_valid", 32'(bus.out_valid), 32'(1));
      chk("stall_diff",      bus.diff,           sat(32'hFFFF_FFFF, 1'b1));
      chk("stall_in_ready",  32'(bus.in_ready),  32'(0));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("stall_release_out_valid", 32'(bus.out_valid), 32'(0));
    chk("stall_release_in_ready",  32'(bus.in_ready),  32'(1));
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("stall_no_ghost_op", 32'(bus.out_valid), 32'(0));
    end

    // Reset mid-operation at idx=2 drops the result entirely.
    issue(32'h0000_00FF, 32'h0000_0100, 32'hFFFF_FFFF, 1'b1, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    void'(exp_q.pop_back());
    chk("midrst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("midrst_in_ready",  32'(bus.in_ready),  32'(1));
    chk("midrst_diff",      bus.diff,           32'h0);
    chk("midrst_bout",      32'(bus.bout),      32'(0));
    chk("midrst_ovf",       32'(bus.ovf),       32'(0));
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("midrst_no_result", 32'(bus.out_valid), 32'(0));
    end
    run_op(32'h5, 32'h3, 32'h2, 1'b0, 1'b0, "after_rst");

    // Idle stretch: nothing moves.
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_in_ready",  32'(bus.in_ready),  32'(1));
      chk("idle_out_valid", 32'(bus.out_valid), 32'(0));
      chk("idle_diff",      bus.diff,           32'h2);
    end

    // Random operands checked against a reference subtract.
    for (int i = 0; i < 8; i++) begin
      ra  = $urandom();
      rb  = $urandom();
      if (i == 0) rb = ra + 32'h1;
      rd  = ra - rb;
      rbo = (ra < rb);
      rov = (ra[31] != rb[31]) && (rd[31] != ra[31]);
      run_op(ra, rb, rd, rbo, rov, $sformatf("rand%0d", i));
    end

    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sub32_serial.md
Name: sub32_serial

Overview:
- Multi-cycle 32-bit subtractor; the inverse-direction companion to the team's combinational 32-bit adder.
- Computes diff = a - b one SLICE-bit slice per clock, starting at the LSB, with a registered borrow chain.
- Reports the unsigned borrow-out and signed overflow.
- Sits on the datapath behind a valid/ready handshake, so upstream and downstream can stall it.

Parameters:
- WIDTH, 32, operand and result width; must be a multiple of SLICE.
- SLICE, 8, bits processed per cycle; NSLICE = WIDTH/SLICE (4 at defaults).

Ports:
- clk  input  1  rising-edge clock, the block's only clock.
- rst_n  input  1  reset; synchronous, active-low (sampled on the rising edge of clk).
- in_valid  input  1  operands a/b are valid.
- in_ready  output  1  block accepts operands (high only in IDLE).
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- out_valid  output  1  diff/bout/ovf are valid.
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  a - b, modulo 2^WIDTH.
- bout  output  1  final borrow; 1 iff a < b unsigned.
- ovf  output  1  signed overflow: (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).

Behaviour:
- Reset (rst_n low at a clk edge), from any state:
  - state=IDLE, in_ready=1 after that edge, out_valid=0, diff=0, bout=0, ovf=0.
  - Internal slice index and borrow cleared.
  - An operation in progress is discarded; no result is emitted.
- States are IDLE, RUN, DONE. All outputs are registered or decoded directly from the state register.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, capture a and b into internal registers, clear borrow, set idx=0, go to RUN.
- RUN:
  - in_ready=0.
  - Each edge computes {borrow', slice} = a[idx] - b[idx] - borrow into the working register, then increments idx.
  - On the edge processing idx=NSLICE-1, load diff, bout (= final borrow) and ovf from the completed working value, then go to DONE.
- DONE:
  - out_valid=1; diff, bout and ovf are held stable.
  - On an edge with out_ready=1, go to IDLE and drop out_valid.
  - in_ready stays 0 until that edge.
- Latency: accept edge to out_valid high is NSLICE edges (4 at defaults).
- Throughput: one result per NSLICE+2 cycles with out_ready held high.
- Outputs diff, bout and ovf change only on the transition into DONE (or on reset). They hold the previous result during IDLE and RUN.
- in_valid while in RUN or DONE is ignored; the upstream must hold its data until it sees in_ready.
- out_ready outside DONE has no effect.
- Boundaries:
  - a==b gives diff=0, bout=0.
  - a=0, b=0xFFFFFFFF gives diff=1, bout=1.
  - The borrow propagates across every slice boundary.

Optional Feature:
- Macro SUB32_SERIAL_SAT_EN.
- Defined: unsigned saturation. If the final borrow is 1, diff loads 0 instead of the wrapped value; bout is still reported as 1, and ovf is computed from the unsaturated value.
- Undefined: diff is always the wrapped modulo-2^WIDTH result.
- Latency and handshake are identical in both builds.

Decomposition:
- Package sub32_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - default constants WIDTH_D=32 and SLICE_D=8;
  - a localparam function for NSLICE and the idx width (clog2).
- One sub-module, sub_slice: combinational SLICE-bit subtract with borrow-in and borrow-out, instantiated once and muxed by idx.
- The top module holds the FSM, the operand, working and output registers, and the flag logic.

Test Plan:
- a=8, b=9, out_ready=1 -> out_valid exactly 4 edges after accept; diff=0xFFFFFFFF, bout=1, ovf=0 (with SAT_EN: diff=0, bout=1).
- a=11, b=1, then a=11, b=15 back-to-back -> diff=10, bout=0; then diff=0xFFFFFFFC, bout=1; in_ready low throughout each operation.
- a=0x80000000, b=1 -> diff=0x7FFFFFFF, bout=0, ovf=1; a=0x000000FF, b=0x00000100 -> borrow crosses a slice boundary, diff=0xFFFFFFFF, bout=1.
- Hold out_ready=0 for 5 cycles in DONE while driving new in_valid -> out_valid and diff stay stable, new operands ignored; release out_ready -> IDLE, in_ready=1 next cycle.
- Assert rst_n=0 for one edge during RUN at idx=2 -> out_valid never rises, all outputs zero, in_ready=1; the next operation a=5, b=3 gives diff=2.
- in_valid=0 idle for 10 cycles -> state stays IDLE and outputs are unchanged.
